// File: rtl/mac_layer_sequencer.sv
// Layer sequencer: time-shares one MAC datapath across Q neurons of D inputs.
// Drives x/weight reads, accumulator control and result-file writes.
module mac_layer_sequencer #(
    parameter int D   = 4,
    parameter int Q   = 3,
    parameter int XAW = 3,
    parameter int WAW = 4,
    parameter int RAW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           mem_ready,
    output logic           rd_en,
    output logic [XAW-1:0] x_addr,
    output logic [WAW-1:0] w_addr,
    output logic           acc_clear,
    output logic           acc_en,
    output logic           res_write,
    output logic [RAW-1:0] res_addr,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [XAW-1:0] I_LAST = XAW'(D - 1);
    localparam logic [RAW-1:0] Q_LAST = RAW'(Q - 1);
    localparam logic [WAW-1:0] W_STEP = WAW'(D);

    state_t         state_q, state_d;
    logic [XAW-1:0] i_q, i_d;
    logic [RAW-1:0] q_q, q_d;
    logic [WAW-1:0] wbase_q, wbase_d;
    logic           acc_en_q, acc_en_d;
    logic           issue;

    assign rd_en     = (state_q == S_READ);
    assign acc_clear = (state_q == S_CLEAR);
    assign res_write = (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign issue     = rd_en & mem_ready;
    assign acc_en    = acc_en_q;
    assign x_addr    = i_q;
    assign w_addr    = wbase_q + WAW'(i_q);
    assign res_addr  = q_q;

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        q_d      = q_q;
        wbase_d  = wbase_q;
        acc_en_d = issue & ~abort;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    i_d     = '0;
                    q_d     = '0;
                    wbase_d = '0;
                end
            end
            S_CLEAR: begin
                i_d     = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (mem_ready) begin
                    if (i_q == I_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + XAW'(1);
                    end
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                if (q_q == Q_LAST) begin
                    state_d = S_DONE;
                end else begin
                    q_d     = q_q + RAW'(1);
                    wbase_d = wbase_q + W_STEP;
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                // Return counters to zero so IDLE presents zero addresses.
                state_d = S_IDLE;
                i_d     = '0;
                q_d     = '0;
                wbase_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            i_d     = '0;
            q_d     = '0;
            wbase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            q_q      <= '0;
            wbase_q  <= '0;
            acc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            q_q      <= q_d;
            wbase_q  <= wbase_d;
            acc_en_q <= acc_en_d;
        end
    end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench for mac_layer_sequencer: D=4/Q=3 main instance
// plus a D=1/Q=1 instance.
module tb_mac_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, mem_ready;
    logic       rd_en, acc_clear, acc_en, res_write, busy, done;
    logic [2:0] x_addr;
    logic [3:0] w_addr;
    logic [1:0] res_addr;

    logic       start1, abort1, mem_ready1;
    logic       rd_en1, acc_clear1, acc_en1, res_write1, busy1, done1;
    logic [0:0] x_addr1, w_addr1, res_addr1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mac_layer_sequencer #(.D(4), .Q(3), .XAW(3), .WAW(4), .RAW(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mem_ready(mem_ready), .rd_en(rd_en), .x_addr(x_addr),
        .w_addr(w_addr), .acc_clear(acc_clear), .acc_en(acc_en),
        .res_write(res_write), .res_addr(res_addr), .busy(busy),
        .done(done)
    );

    mac_layer_sequencer #(.D(1), .Q(1), .XAW(1), .WAW(1), .RAW(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .mem_ready(mem_ready1), .rd_en(rd_en1), .x_addr(x_addr1),
        .w_addr(w_addr1), .acc_clear(acc_clear1), .acc_en(acc_en1),
        .res_write(res_write1), .res_addr(res_addr1), .busy(busy1),
        .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"}, rd_en, 0);
        chk({tag, "_clr"}, acc_clear, 0);
        chk({tag, "_acc"}, acc_en, 0);
        chk({tag, "_wr"}, res_write, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_x"}, x_addr, 0);
        chk({tag, "_w"}, w_addr, 0);
        chk({tag, "_ra"}, res_addr, 0);
    endtask

    // Full pass with mem_ready=1; timetable: neuron n = (c-1)/7,
    // phase 0 CLEAR, 1..4 READ, 5 DRAIN, 6 WRITE; done at 22.
    task automatic pass_check(input string tag, input bit hold);
        int n, p, n_acc, n_clr;
        n_acc = 0;
        n_clr = 0;
        cyc = 0;
        start = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            if (!hold) start = 1'b0;
            if (acc_en) n_acc++;
            if (acc_clear) n_clr++;
            if (c <= 21) begin
                n = (c - 1) / 7;
                p = (c - 1) % 7;
                chk($sformatf("%s_c%0d_rd", tag, c), rd_en,
                    (p >= 1 && p <= 4));
                chk($sformatf("%s_c%0d_clr", tag, c), acc_clear, (p == 0));
                chk($sformatf("%s_c%0d_acc", tag, c), acc_en,
                    (p >= 2 && p <= 5));
                chk($sformatf("%s_c%0d_wr", tag, c), res_write, (p == 6));
                chk($sformatf("%s_c%0d_busy", tag, c), busy, 1);
                chk($sformatf("%s_c%0d_done", tag, c), done, 0);
                if (p >= 1 && p <= 4) begin
                    chk($sformatf("%s_c%0d_x", tag, c), x_addr, p - 1);
                    chk($sformatf("%s_c%0d_w", tag, c), w_addr,
                        n * 4 + p - 1);
                end
                if (p == 6)
                    chk($sformatf("%s_c%0d_ra", tag, c), res_addr, n);
            end else if (c == 22) begin
                chk({tag, "_c22_done"}, done, 1);
                chk({tag, "_c22_busy"}, busy, 1);
                chk({tag, "_c22_wr"}, res_write, 0);
            end else begin
                chk_zero({tag, "_c23"});
            end
        end
        chk({tag, "_acc_pulses"}, n_acc, 12);
        chk({tag, "_clr_pulses"}, n_clr, 3);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int budget;
        budget = 0;
        while (!done && budget < 60) begin
            tick();
            budget++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
    endtask

    initial begin
        int seen_wr, seen_done;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mem_ready = 1'b1;
        start1 = 1'b0;
        abort1 = 1'b0;
        mem_ready1 = 1'b1;
        #22;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_zero("idle");

        pass_check("p1", 1'b0);

        // Stall: mem_ready low for two cycles at neuron 1, i=2.
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(10);
        tick();
        mem_ready = 1'b0;
        chk("st11_rd", rd_en, 1);
        chk("st11_x", x_addr, 2);
        chk("st11_w", w_addr, 6);
        tick();
        chk("st12_rd", rd_en, 1);
        chk("st12_x", x_addr, 2);
        chk("st12_w", w_addr, 6);
        chk("st12_acc", acc_en, 0);
        tick();
        mem_ready = 1'b1;
        chk("st13_x", x_addr, 2);
        chk("st13_w", w_addr, 6);
        chk("st13_acc", acc_en, 0);
        tick();
        chk("st14_acc", acc_en, 1);
        chk("st14_x", x_addr, 3);
        wait_done("st", 24);
        tick();
        chk("st_after_busy", busy, 0);

        // Abort during READ of neuron 1.
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(10);
        chk("ab10_rd", rd_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_zero("ab11");
        seen_wr = 0;
        seen_done = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (res_write) seen_wr++;
            if (done) seen_done++;
        end
        chk("ab_no_write", seen_wr, 0);
        chk("ab_no_done", seen_done, 0);
        pass_check("p_ab", 1'b0);

        // Asynchronous reset mid-WRITE of neuron 0.
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(7);
        chk("rs7_wr", res_write, 1);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("rs_async");
        @(negedge clk);
        rst = 1'b1;
        seen_wr = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (busy || res_write) seen_wr++;
        end
        chk("rs_stay_idle", seen_wr, 0);

        // start held across a pass: second pass from the IDLE cycle.
        pass_check("p_hold", 1'b1);
        tick();
        start = 1'b0;
        chk("hold_c24_clr", acc_clear, 1);
        chk("hold_c24_busy", busy, 1);
        wait_done("hold2", 45);
        tick();
        chk("hold2_idle", busy, 0);

        // D=1, Q=1 instance.
        cyc = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s1_c1_clr", acc_clear1, 1);
        tick();
        chk("s1_c2_rd", rd_en1, 1);
        chk("s1_c2_w", w_addr1, 0);
        tick();
        chk("s1_c3_acc", acc_en1, 1);
        chk("s1_c3_rd", rd_en1, 0);
        tick();
        chk("s1_c4_wr", res_write1, 1);
        chk("s1_c4_ra", res_addr1, 0);
        tick();
        chk("s1_c5_done", done1, 1);
        tick();
        chk("s1_c6_busy", busy1, 0);
        chk("s1_c6_done", done1, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_layer_sequencer.md
# mac_layer_sequencer

Sequencer that time-shares one multiply-accumulate datapath across a layer of Q neurons, each with D inputs. For every neuron it clears the accumulator, streams D input/weight address pairs to the x and weight memories, and enables accumulation one cycle after each read. It then writes the accumulator into the result register file. It sits between the top-level start/done handshake and the x memory, weight memory, accumulator and result file of the neuron datapath.

## Interface
- D, 4, inputs per neuron (≥1)
- Q, 3, neurons per layer (≥1)
- XAW, 3, x-address width; 2^XAW ≥ D
- WAW, 4, weight-address width; 2^WAW ≥ Q·D
- RAW, 2, result-address width; 2^RAW ≥ Q

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a layer pass; sampled only in IDLE
- abort  in  1  synchronous cancel of a pass in progress
- mem_ready  in  1  x/weight memories can accept a read this cycle
- rd_en  out  1  read request to x and weight memories
- x_addr  out  XAW  x-memory address
- w_addr  out  WAW  weight-memory address
- acc_clear  out  1  clear accumulator
- acc_en  out  1  accumulate memory data (registered)
- res_write  out  1  write accumulator into result file
- res_addr  out  RAW  result-file address (= neuron index q)
- busy  out  1  pass in progress
- done  out  1  one-cycle pass-complete pulse

## Operation
- Counters: i (input index, 0..D-1), q (neuron index, 0..Q-1), wbase (= q·D, advanced by adding D; no multiplier).
- x_addr = i; w_addr = wbase + i; res_addr = q. All are zero in IDLE.
- issue = rd_en & mem_ready. acc_en is a flop of issue.
- States:
  - IDLE: busy=0. start=1 → CLEAR, with q=0 and wbase=0.
  - CLEAR: acc_clear=1 for one cycle; i=0 → READ.
  - READ: rd_en=1. On issue: if i==D-1 → DRAIN, else i+1.
  - DRAIN: one cycle for the final acc_en → WRITE.
  - WRITE: res_write=1. If q==Q-1 → DONE; else q+1, wbase+D → CLEAR.
  - DONE: done=1 → IDLE.
- busy=1 in every state except IDLE. rd_en, acc_clear, res_write, busy and done are Moore decodes of the state.
- mem_ready=0 in READ: rd_en stays 1, addresses are held, i does not advance, acc_en=0 on the next cycle. mem_ready is ignored outside READ.
- start while busy is ignored. A start pulse arriving in the same cycle as DONE is ignored; IDLE must see start again.
- abort=1 in any non-IDLE state → IDLE on the next edge. Effects:
  - no res_write and no done for that pass;
  - counters are zeroed;
  - acc_en is forced to 0 on that edge.
- abort has priority over all other transitions. It has no effect in IDLE.
- Counter wrap is impossible by construction: i stops at D-1 and q stops at Q-1.

## Timing
- Reset (rst=0, asynchronous): state=IDLE and i, q, wbase=0. All outputs are 0 immediately: rd_en, acc_clear, acc_en, res_write, busy, done, x_addr, w_addr, res_addr. Reset mid-pass discards the pass with no further writes.
- Cycle 0 is the edge that samples start. CLEAR occupies cycle 1.
- Each neuron, with mem_ready held at 1, takes D+3 cycles: CLEAR, then D×READ, then DRAIN, then WRITE.
- Each cycle of mem_ready=0 in READ adds one cycle.
- done is high in cycle Q·(D+3)+1; busy falls in the next cycle. The earliest new start is sampled in that IDLE cycle.
- acc_en for read k is high exactly one cycle after issue k. The final acc_en of a neuron coincides with DRAIN, so res_write follows the last accumulate by one cycle.

## Test plan
- D=4, Q=3, mem_ready=1, start pulse at cycle 0:
  - w_addr sequence is 0,1,2,3 / 4,5,6,7 / 8,9,10,11;
  - x_addr sequence is 0..3 for each neuron;
  - res_write is high at cycles 7, 14 and 21 with res_addr 0, 1, 2;
  - done is high at cycle 22 only;
  - exactly 12 acc_en pulses and 3 acc_clear pulses.
- mem_ready=0 for 2 cycles while i=2 of neuron 1:
  - x_addr=2 and w_addr=6 are held with rd_en=1;
  - no acc_en during the stall;
  - done moves to cycle 24.
- abort asserted in READ of neuron 1:
  - next cycle is IDLE with all outputs 0;
  - no res_write for q=1, no done;
  - a following start produces a full, correct pass.
- rst driven low mid-WRITE, asynchronously between edges: outputs go to 0 immediately; after release the block stays IDLE until start.
- start held at 1 throughout the pass: it is ignored while busy; a second pass begins from the IDLE cycle after done.
- D=1, Q=1: sequence is CLEAR, READ, DRAIN, WRITE, DONE, with done at cycle 5 and w_addr=0.
